// File: rtl/note_sequencer_ctrl_pkg.sv
// Shared types and constants for the note sequencer control block.
package note_seq_pkg;

    localparam int unsigned NUM_SLOTS_DEF    = 16;
    localparam int unsigned SLOT_W           = $clog2(NUM_SLOTS_DEF);
    localparam int unsigned CNT_W            = SLOT_W + 1;
    localparam int unsigned PLAY_LOAD_CYCLES = 3;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_REC_STROBE = 3'd1,
        S_REC_GAP    = 3'd2,
        S_PLAY_LOAD  = 3'd3,
        S_PLAY_HOLD  = 3'd4,
        S_PLAY_GAP   = 3'd5
    } state_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/note_sequencer_ctrl_tick_timer.sv
// Loadable down-counter; o_done is high on the last cycle of the loaded interval.
module tick_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_done
);

    logic [WIDTH-1:0] r_count;
    logic             r_run;

    always_ff @(posedge clk) begin
        if (!reset || i_clear) begin
            r_count <= '0;
            r_run   <= 1'b0;
        end else if (i_start) begin
            r_count <= i_load_val;
            r_run   <= 1'b1;
        end else if (r_run) begin
            if (r_count == '0)
                r_run <= 1'b0;
            else
                r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_done = r_run && (r_count == '0);

endmodule

// File: rtl/note_sequencer_ctrl.sv
// Record/playback control FSM for the note-storage datapath.
// Define LOOP_PLAYBACK_EN to repeat the stored sequence until play_stop.
module note_sequencer_ctrl
    import note_seq_pkg::*;
#(
    parameter int unsigned NUM_SLOTS  = NUM_SLOTS_DEF,
    parameter int unsigned NOTE_TICKS = 12_500_000,
    parameter int unsigned GAP_TICKS  = 1_250_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              record_key,
    input  logic              play_start,
    input  logic              play_stop,
    output logic              ld_note,
    output logic              ld_play,
    output logic [SLOT_W-1:0] note_counter,
    output logic              next_note_en,
    output logic              display_note,
    output logic [CNT_W-1:0]  rec_count,
    output logic              rec_full,
    output logic              busy
);

    localparam int unsigned      TMR_W     = $clog2(max_u(NOTE_TICKS, GAP_TICKS) + 1);
    localparam logic [TMR_W-1:0] NOTE_LOAD = TMR_W'(NOTE_TICKS - 1);
    localparam logic [TMR_W-1:0] GAP_LOAD  = TMR_W'(GAP_TICKS - 1);
    localparam logic [1:0]       LOAD_LAST = 2'(PLAY_LOAD_CYCLES - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(NUM_SLOTS);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_key_low;
    logic [1:0]        r_load_cnt;
    logic [SLOT_W-1:0] r_note_counter;
    logic [CNT_W-1:0]  r_rec_count;

    logic              w_rec_edge;
    logic              w_full;
    logic              w_playing;
    logic              w_load_last;
    logic              w_last_note;
    logic              w_tmr_start;
    logic [TMR_W-1:0]  w_tmr_load;
    logic              w_tmr_done;

    // r_key_low clears at reset, so a key already held through reset is not an edge
    assign w_rec_edge  = record_key && r_key_low;
    assign w_full      = (r_rec_count == FULL_CNT);
    assign w_playing   = (r_state == S_PLAY_LOAD) || (r_state == S_PLAY_HOLD) ||
                         (r_state == S_PLAY_GAP);
    assign w_load_last = (r_state == S_PLAY_LOAD) && (r_load_cnt == LOAD_LAST);
    assign w_last_note = ({1'b0, r_note_counter} == (r_rec_count - CNT_W'(1)));

    always_comb begin
        w_state_nxt = r_state;
        w_tmr_start = 1'b0;
        w_tmr_load  = '0;
        case (r_state)
            S_IDLE: begin
                if (!play_stop) begin
                    if (play_start && (r_rec_count != '0))
                        w_state_nxt = S_PLAY_LOAD;
                    else if (w_rec_edge && !w_full)
                        w_state_nxt = S_REC_STROBE;
                end
            end
            S_REC_STROBE: w_state_nxt = S_REC_GAP;
            S_REC_GAP:    w_state_nxt = S_IDLE;
            S_PLAY_LOAD: begin
                if (w_load_last) begin
                    w_state_nxt = S_PLAY_HOLD;
                    w_tmr_start = 1'b1;
                    w_tmr_load  = NOTE_LOAD;
                end
            end
            S_PLAY_HOLD: begin
                if (w_tmr_done) begin
                    w_state_nxt = S_PLAY_GAP;
                    w_tmr_start = 1'b1;
                    w_tmr_load  = GAP_LOAD;
                end
            end
            S_PLAY_GAP: begin
                if (w_tmr_done) begin
`ifdef LOOP_PLAYBACK_EN
                    w_state_nxt = S_PLAY_LOAD;
`else
                    w_state_nxt = w_last_note ? S_IDLE : S_PLAY_LOAD;
`endif
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_playing && play_stop) begin
            w_state_nxt = S_IDLE;
            w_tmr_start = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state        <= S_IDLE;
            r_key_low      <= 1'b0;
            r_load_cnt     <= '0;
            r_note_counter <= '0;
            r_rec_count    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_key_low  <= ~record_key;
            r_load_cnt <= ((r_state == S_PLAY_LOAD) && (w_state_nxt == S_PLAY_LOAD)) ?
                          r_load_cnt + 2'd1 : '0;
            if ((r_state == S_IDLE) && (w_state_nxt == S_REC_STROBE))
                r_rec_count <= r_rec_count + CNT_W'(1);
            if (w_state_nxt == S_IDLE)
                r_note_counter <= '0;
            else if ((r_state == S_PLAY_GAP) && (w_state_nxt == S_PLAY_LOAD))
                r_note_counter <= w_last_note ? '0 : r_note_counter + SLOT_W'(1);
        end
    end

    tick_timer #(
        .WIDTH(TMR_W)
    ) u_tick_timer (
        .clk       (clk),
        .reset     (reset),
        .i_start   (w_tmr_start),
        .i_clear   (w_state_nxt == S_IDLE),
        .i_load_val(w_tmr_load),
        .o_done    (w_tmr_done)
    );

    assign ld_note      = (r_state == S_REC_STROBE);
    assign ld_play      = w_playing;
    assign note_counter = r_note_counter;
    assign next_note_en = w_load_last;
    assign display_note = (r_state == S_PLAY_HOLD);
    assign rec_count    = r_rec_count;
    assign rec_full     = w_full;
    assign busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_note_sequencer_ctrl.sv
// Scoreboard bench for note_sequencer_ctrl with short tempo (NOTE_TICKS=8, GAP_TICKS=2).
module tb_note_sequencer_ctrl;
    import note_seq_pkg::*;

    localparam int unsigned NT = 8;
    localparam int unsigned GT = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              record_key = 1'b0;
    logic              play_start = 1'b0;
    logic              play_stop = 1'b0;
    logic              ld_note;
    logic              ld_play;
    logic [SLOT_W-1:0] note_counter;
    logic              next_note_en;
    logic              display_note;
    logic [CNT_W-1:0]  rec_count;
    logic              rec_full;
    logic              busy;

    always #5 clk = ~clk;

    note_sequencer_ctrl #(
        .NUM_SLOTS (16),
        .NOTE_TICKS(NT),
        .GAP_TICKS (GT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .record_key  (record_key),
        .play_start  (play_start),
        .play_stop   (play_stop),
        .ld_note     (ld_note),
        .ld_play     (ld_play),
        .note_counter(note_counter),
        .next_note_en(next_note_en),
        .display_note(display_note),
        .rec_count   (rec_count),
        .rec_full    (rec_full),
        .busy        (busy)
    );

    typedef struct {
        int nc;
        int low;
    } nne_t;

    int   total = 0;
    int   bad = 0;
    int   exp_rec[$];
    nne_t exp_nne[$];
    int   exp_hold[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic unexpected(input string name);
        total++;
        bad++;
        $display("FAIL %s: event seen, required none", name);
    endtask

    // Monitor: pops expected events as the DUT presents them
    int   cyc = 0;
    int   last_ld = -100;
    int   hi = 0;
    int   low = 0;
    nne_t e;

    always begin
        @(posedge clk);
        #1;
        cyc++;
        if (ld_note) begin
            chk("ld_note_spacing_ok", 32'(cyc - last_ld >= 2), 1);
            last_ld = cyc;
            if (exp_rec.size() == 0) unexpected("ld_note_extra");
            else chk("ld_note_rec_count", 32'(rec_count), exp_rec.pop_front());
        end
        if (ld_play && !display_note) low++;
        else low = 0;
        if (next_note_en) begin
            if (exp_nne.size() == 0) unexpected("next_note_en_extra");
            else begin
                e = exp_nne.pop_front();
                chk("nne_note_counter", 32'(note_counter), e.nc);
                chk("nne_cycles_since_sound", 32'(low), e.low);
                chk("nne_ld_play", 32'(ld_play), 1);
            end
        end
        if (display_note) hi++;
        else if (hi != 0) begin
            if (exp_hold.size() == 0) unexpected("display_note_extra");
            else chk("display_note_len", 32'(hi), exp_hold.pop_front());
            hi = 0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press();
        record_key = 1'b1;
        tick(1);
        record_key = 1'b0;
        tick(2);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(1);
    endtask

    task automatic pulse_start();
        play_start = 1'b1;
        tick(1);
        play_start = 1'b0;
    endtask

    task automatic stop_now();
        play_stop = 1'b1;
        tick(1);
        play_stop = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && busy; i++) @(negedge clk);
        chk("wait_idle_busy", 32'(busy), 0);
    endtask

    task automatic wait_sound(input int nc, input int budget);
        for (int i = 0; i < budget && !(display_note && note_counter == SLOT_W'(nc)); i++)
            @(negedge clk);
        chk("wait_sound_display", 32'(display_note), 1);
    endtask

    task automatic wait_nne_drained(input int budget);
        for (int i = 0; i < budget && exp_nne.size() != 0; i++) @(negedge clk);
        chk("wait_nne_drained", 32'(exp_nne.size()), 0);
    endtask

    task automatic push_nne(input int nc, input int lw);
        nne_t t;
        t.nc  = nc;
        t.low = lw;
        exp_nne.push_back(t);
    endtask

    initial begin
        // 1: reset with record_key held
        record_key = 1'b1;
        tick(3);
        chk("rst_ld_note", 32'(ld_note), 0);
        chk("rst_ld_play", 32'(ld_play), 0);
        chk("rst_note_counter", 32'(note_counter), 0);
        chk("rst_next_note_en", 32'(next_note_en), 0);
        chk("rst_display_note", 32'(display_note), 0);
        chk("rst_rec_count", 32'(rec_count), 0);
        chk("rst_rec_full", 32'(rec_full), 0);
        chk("rst_busy", 32'(busy), 0);
        reset = 1'b1;
        tick(4);
        chk("held_key_rec_count", 32'(rec_count), 0);
        chk("held_key_busy", 32'(busy), 0);
        record_key = 1'b0;
        tick(2);

        // 2: three record edges
        exp_rec.push_back(1);
        exp_rec.push_back(2);
        exp_rec.push_back(3);
        repeat (3) press();
        chk("rec3_rec_count", 32'(rec_count), 3);
        chk("rec3_rec_full", 32'(rec_full), 0);
        chk("rec3_pending", 32'(exp_rec.size()), 0);

        // 4: play three notes; a record press mid-play is ignored
        push_nne(0, 3);
        push_nne(1, 5);
        push_nne(2, 5);
        exp_hold.push_back(NT);
        exp_hold.push_back(NT);
        exp_hold.push_back(NT);
`ifdef LOOP_PLAYBACK_EN
        push_nne(0, 5);
`endif
        pulse_start();
        tick(5);
        record_key = 1'b1;
        tick(1);
        record_key = 1'b0;
`ifdef LOOP_PLAYBACK_EN
        wait_nne_drained(100);
        stop_now();
`else
        wait_idle(100);
`endif
        chk("play3_busy", 32'(busy), 0);
        chk("play3_ld_play", 32'(ld_play), 0);
        chk("play3_rec_count", 32'(rec_count), 3);
        chk("play3_nne_pending", 32'(exp_nne.size()), 0);
        chk("play3_hold_pending", 32'(exp_hold.size()), 0);

        // 5: stop during slot 1 hold, after 4 sounding cycles
        push_nne(0, 3);
        push_nne(1, 5);
        exp_hold.push_back(NT);
        exp_hold.push_back(4);
        pulse_start();
        wait_sound(1, 100);
        tick(3);
        stop_now();
        chk("stop_busy", 32'(busy), 0);
        chk("stop_ld_play", 32'(ld_play), 0);
        chk("stop_note_counter", 32'(note_counter), 0);
        chk("stop_display_note", 32'(display_note), 0);
        chk("stop_nne_pending", 32'(exp_nne.size()), 0);
        chk("stop_hold_pending", 32'(exp_hold.size()), 0);

        // 3: seventeen edges into an empty memory
        do_reset();
        chk("rerst_rec_count", 32'(rec_count), 0);
        for (int i = 1; i <= 16; i++) exp_rec.push_back(i);
        repeat (17) press();
        chk("full_rec_count", 32'(rec_count), 16);
        chk("full_rec_full", 32'(rec_full), 1);
        chk("full_pending", 32'(exp_rec.size()), 0);

        // 6: start with nothing stored, then start and record edge together
        do_reset();
        pulse_start();
        tick(3);
        chk("empty_start_busy", 32'(busy), 0);
        chk("empty_start_ld_play", 32'(ld_play), 0);
        exp_rec.push_back(1);
        press();
        chk("one_rec_count", 32'(rec_count), 1);
        push_nne(0, 3);
        exp_hold.push_back(1);
        record_key = 1'b1;
        play_start = 1'b1;
        tick(1);
        record_key = 1'b0;
        play_start = 1'b0;
        chk("both_busy", 32'(busy), 1);
        chk("both_ld_play", 32'(ld_play), 1);
        chk("both_rec_count", 32'(rec_count), 1);
        wait_sound(0, 20);
        stop_now();
        chk("both_stop_busy", 32'(busy), 0);
        chk("both_end_rec_count", 32'(rec_count), 1);
        chk("both_nne_pending", 32'(exp_nne.size()), 0);
        chk("both_hold_pending", 32'(exp_hold.size()), 0);
        chk("both_rec_pending", 32'(exp_rec.size()), 0);

        tick(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

endmodule
